// File: rtl/tdl_tdc_channel.sv
// tdl_tdc_channel
//
// Tapped-delay-line TDC channel front end. A hit edge runs down a chain of
// N_TAPS buffer stages. Every tap is sampled on clk through a two-flop
// synchroniser. The resulting thermometer code is encoded into a fine time.
// The fine time is paired with a free-running coarse counter and offered as
// one timestamp over a valid/ready handshake. A new hit that arrives while the
// held timestamp is still waiting for acceptance is dropped and counted.
//
// Optional feature: define TDL_BUBBLE_FIX_EN to add a combinational
// 3-input majority filter in front of the fine encoder. The filter removes
// single-tap bubbles from the thermometer code. Event detection always uses
// the raw synchronised tap 0.
//
// Parameters:
//   N_TAPS    number of delay taps (>= 4)
//   COARSE_W  coarse counter width
//   MISS_W    missed-hit counter width
//   FINE_W    derived fine code width, $clog2(N_TAPS+1)
//
// Ports:
//   clk        sampling and system clock
//   rst        asynchronous active-high reset
//   enable     arms hit capture (only masks new events)
//   hit        asynchronous hit input into tap 0
//   test_en    selects test_taps instead of the delay chain outputs
//   test_taps  forced tap vector, bit 0 nearest hit
//   ts_valid   timestamp valid
//   ts_ready   consumer accepts the timestamp
//   ts_coarse  coarse stamp (counter value when the taps were sampled)
//   ts_fine    fine stamp, 0..N_TAPS
//   miss_cnt   saturating count of hits dropped under backpressure
//   busy       high while a timestamp is held

module tdl_tdc_channel #(
  parameter  int N_TAPS   = 32,
  parameter  int COARSE_W = 16,
  parameter  int MISS_W   = 8,
  localparam int FINE_W   = $clog2(N_TAPS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                hit,
  input  logic                test_en,
  input  logic [N_TAPS-1:0]   test_taps,
  output logic                ts_valid,
  input  logic                ts_ready,
  output logic [COARSE_W-1:0] ts_coarse,
  output logic [FINE_W-1:0]   ts_fine,
  output logic [MISS_W-1:0]   miss_cnt,
  output logic                busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [N_TAPS-1:0]   d;
  logic [N_TAPS-1:0]   t;
  logic [N_TAPS-1:0]   s1;
  logic [N_TAPS-1:0]   s2;
  logic [N_TAPS-1:0]   corr;
  logic                p;
  logic [COARSE_W-1:0] c;
  logic [COARSE_W-1:0] c1;
  logic [COARSE_W-1:0] c2;
  logic [0:0]          state;
  logic                ev;
  logic [FINE_W-1:0]   fine;

  // The delay chain. Each stage is its own generate scope with a keep
  // attribute, so synthesis cannot collapse the buffers. Collapsing them
  // would destroy the delay line.
  genvar gi;
  generate
    for (gi = 0; gi < N_TAPS; gi++) begin : g_chain
      (* keep = "true" *) logic tap;
      if (gi == 0) begin : g_first
        assign tap = hit;
      end else begin : g_next
        assign tap = g_chain[gi-1].tap;
      end
      assign d[gi] = tap;
    end
  endgenerate

  assign t = test_en ? test_taps : d;

  // Two-flop synchroniser on every tap. p keeps the previous synchronised
  // tap 0 so that a rising edge can be detected. The coarse counter has two
  // pipeline copies. The stamp therefore lines up with the cycle in which
  // the taps were first sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      p  <= 1'b0;
      c  <= '0;
      c1 <= '0;
      c2 <= '0;
    end else begin
      s1 <= t;
      s2 <= s1;
      p  <= s2[0];
      c  <= c + COARSE_W'(1);
      c1 <= c;
      c2 <= c1;
    end
  end

  assign ev = enable & s2[0] & ~p;

`ifdef TDL_BUBBLE_FIX_EN
  // Majority of each tap and its two neighbours. Below tap 0 the code is
  // treated as a 1 and beyond the last tap as a 0. A lone bubble inside the
  // run of ones is therefore filled, and a lone stray one past the edge is
  // removed.
  logic [N_TAPS+1:0] ext;
  assign ext = {1'b0, s2, 1'b1};

  always_comb begin
    corr = '0;
    for (int i = 0; i < N_TAPS; i++) begin
      corr[i] = (ext[i] & ext[i+1]) | (ext[i+1] & ext[i+2]) | (ext[i] & ext[i+2]);
    end
  end
`else
  assign corr = s2;
`endif

  // Fine encoder. It counts the unbroken run of ones starting at tap 0. Any
  // ones that appear after the first zero are ignored.
  always_comb begin
    logic run;
    fine = '0;
    run  = 1'b1;
    for (int i = 0; i < N_TAPS; i++) begin
      run = run & corr[i];
      if (run) begin
        fine = fine + FINE_W'(1);
      end
    end
  end

  // Capture FSM. In HOLD a new event is accepted only if the held stamp
  // leaves in the same cycle. Otherwise the held stamp stays frozen and the
  // new hit is counted as missed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ts_coarse <= '0;
      ts_fine   <= '0;
      miss_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ev) begin
            ts_coarse <= c2;
            ts_fine   <= fine;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (ev && ts_ready) begin
            ts_coarse <= c2;
            ts_fine   <= fine;
          end else if (ev) begin
            if (miss_cnt != '1) begin
              miss_cnt <= miss_cnt + MISS_W'(1);
            end
          end else if (ts_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ts_valid = (state == HOLD);
  assign busy     = (state == HOLD);

endmodule
